// File: rtl/brisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brisc_pkg
//  Description : Shared types for the main-memory model. Defines the request
//                opcode and partial-store size enums, plus a helper that
//                flags naturally-misaligned partial stores.
//  Revision    : 1.0 - initial release
// ============================================================================
package brisc_pkg;

    typedef enum logic [1:0] {
        MEM_READ       = 2'd0,
        MEM_WRITE_LINE = 2'd1,
        MEM_WRITE_PART = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    localparam int MEM_WORD_BYTES = 4;

    // A half must sit on an even byte, a word on a multiple of four.
    function automatic logic mem_is_misaligned(input mem_size_e size,
                                               input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (size)
            SIZE_H:  r = addr_lo[0];
            SIZE_W:  r = (addr_lo != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rsp_fifo
//  Description : Small synchronous FIFO holding read responses {id, data}
//                between the fixed-latency delay line and the response port.
//  Ports       : clk, rst (async, active-high)
//                i_push / i_push_data  : enqueue one entry
//                i_pop                 : dequeue the head entry
//                o_pop_data            : head entry (valid when !o_empty)
//                o_full / o_empty      : occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rsp_fifo #(
    parameter int WIDTH = 130,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_en;
    logic               w_pop_en;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_push_en = i_push & ~o_full;
    assign w_pop_en  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; the empty flag qualifies it.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = r_mem[r_rd_ptr];

    // The upstream credit scheme must never let an entry arrive while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule
`default_nettype wire

// File: rtl/banked_line_memory.sv
`default_nettype none
// ============================================================================
//  Module      : banked_line_memory
//  Description : Line-organised main-memory model. Accepts line reads, full
//                line writebacks and aligned byte/half/word stores on a
//                valid/ready channel; returns read lines in order after a
//                fixed LATENCY with up to MAX_OUTSTANDING reads in flight.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_ready/req_op/req_size/req_addr/req_wdata/req_id
//                rsp_valid/rsp_ready/rsp_data/rsp_id
//                err_misaligned : sticky, set when a misaligned store is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module banked_line_memory
    import brisc_pkg::*;
#(
    parameter int LINE_WIDTH      = 128,
    parameter int DEPTH_LINES     = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int LATENCY         = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_WIDTH        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  mem_op_e                  req_op,
    input  mem_size_e                req_size,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0]    req_wdata,
    input  logic [ID_WIDTH-1:0]      req_id,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [LINE_WIDTH-1:0]    rsp_data,
    output logic [ID_WIDTH-1:0]      rsp_id,
    output logic                     err_misaligned
);

    localparam int c_line_bytes = LINE_WIDTH / 8;
    localparam int c_off_w      = $clog2(c_line_bytes);
    localparam int c_idx_w      = $clog2(DEPTH_LINES);
    localparam int c_cnt_w      = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_entry_w    = LINE_WIDTH + ID_WIDTH;
    localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    w_accept;
    logic                    w_is_read;
    logic                    w_pop;
    logic                    w_misaligned;
    logic [c_off_w-1:0]      w_offset;
    logic [c_idx_w-1:0]      w_index;
    logic [c_line_bytes-1:0] w_lane_mask;
    logic [LINE_WIDTH-1:0]   w_bit_mask;
    logic [LINE_WIDTH-1:0]   w_wr_data;
    logic                    w_wr_en;
    logic                    w_set_err;

    assign w_accept     = req_valid & req_ready;
    assign w_is_read    = w_accept & (req_op == MEM_READ);
    assign w_offset     = req_addr[c_off_w-1:0];
    assign w_index      = req_addr[c_off_w +: c_idx_w];
    assign w_misaligned = mem_is_misaligned(req_size, req_addr[1:0]);

    // Storage write-enable / byte-lane mask generation.
    always_comb begin
        w_lane_mask = '0;
        w_wr_data   = '0;
        w_wr_en     = 1'b0;
        w_set_err   = 1'b0;
        if (w_accept) begin
            case (req_op)
                MEM_WRITE_LINE: begin
                    w_lane_mask = '1;
                    w_wr_data   = req_wdata;
                    w_wr_en     = 1'b1;
                end
                MEM_WRITE_PART: begin
                    if (w_misaligned) begin
                        w_set_err = 1'b1;
                    end else begin
                        // Little-endian: byte k of the store lands at offset+k.
                        w_wr_data = LINE_WIDTH'(req_wdata[MEM_WORD_BYTES*8-1:0]) << {w_offset, 3'b000};
                        case (req_size)
                            SIZE_B:  w_lane_mask = c_line_bytes'(1)  << w_offset;
                            SIZE_H:  w_lane_mask = c_line_bytes'(3)  << w_offset;
                            SIZE_W:  w_lane_mask = c_line_bytes'(15) << w_offset;
                            default: w_lane_mask = '0;
                        endcase
                        w_wr_en = |w_lane_mask;
                    end
                end
                default: ;
            endcase
        end
        for (int b = 0; b < c_line_bytes; b++) begin
            w_bit_mask[b*8 +: 8] = {8{w_lane_mask[b]}};
        end
    end

    // ------------------------------------------------------------------
    // Line storage: deliberately not reset so contents survive reset.
    // ------------------------------------------------------------------
    logic [LINE_WIDTH-1:0] r_mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_index] <= (r_mem[w_index] & ~w_bit_mask) | (w_wr_data & w_bit_mask);
        end
    end

    // ------------------------------------------------------------------
    // Fixed-latency delay line. Stage 0 captures the line at acceptance,
    // so a read sees every write accepted on an earlier edge.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0]    r_dl_valid;
    logic [ID_WIDTH-1:0]   r_dl_id   [LATENCY];
    logic [LINE_WIDTH-1:0] r_dl_data [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dl_valid <= '0;
        end else begin
            r_dl_valid[0] <= w_is_read;
            for (int s = 1; s < LATENCY; s++) begin
                r_dl_valid[s] <= r_dl_valid[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_is_read) begin
            r_dl_id[0]   <= req_id;
            r_dl_data[0] <= r_mem[w_index];
        end
        for (int s = 1; s < LATENCY; s++) begin
            r_dl_id[s]   <= r_dl_id[s-1];
            r_dl_data[s] <= r_dl_data[s-1];
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [c_entry_w-1:0] w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    mem_rsp_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (r_dl_valid[LATENCY-1]),
        .i_push_data ({r_dl_id[LATENCY-1], r_dl_data[LATENCY-1]}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_rdata),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign rsp_valid = ~w_fifo_empty;
    assign w_pop     = rsp_valid & rsp_ready;
    // FIFO payload is unreset; force zeros while nothing is queued.
    assign {rsp_id, rsp_data} = w_fifo_empty ? '0 : w_fifo_rdata;

    // ------------------------------------------------------------------
    // Read credits: counts reads accepted but not yet popped, covering both
    // the delay line and the FIFO, so the FIFO can never overflow.
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_outstanding;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_is_read, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_one;
                2'b01:   r_outstanding <= r_outstanding - c_one;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Registered-only ready: a pop this cycle frees a credit next cycle.
    assign req_ready = (r_outstanding < c_max_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_misaligned <= 1'b0;
        end else if (w_set_err) begin
            err_misaligned <= 1'b1;
        end
    end

    // Upper address bits wrap by design; FIFO full is implied by the credits.
    logic w_unused;
    assign w_unused = ^{req_addr[ADDRESS_WIDTH-1:c_off_w+c_idx_w], w_fifo_full};

endmodule
`default_nettype wire

// File: doc/banked_line_memory.md
# banked_line_memory

Parametrised main-memory model behind the L1 caches. It accepts line reads, full-line writebacks and naturally aligned byte/half/word stores over a valid/ready request channel. It returns read lines after a fixed, configurable transfer latency with in-order tagged responses. Up to MAX_OUTSTANDING reads may be in flight, and the response side supports backpressure.

## Interface
- LINE_WIDTH, 128: fill/writeback line width in bits; multiple of 32.
- DEPTH_LINES, 32: number of lines stored; power of two.
- ADDRESS_WIDTH, 32: byte address width.
- LATENCY, 5: cycles from read acceptance to earliest rsp_valid; ≥1.
- MAX_OUTSTANDING, 4: reads accepted but not yet popped; ≥1.
- ID_WIDTH, 2: request tag width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at the clk edge.
- req_op  in  mem_op_e  MEM_READ, MEM_WRITE_LINE or MEM_WRITE_PART.
- req_size  in  mem_size_e  SIZE_B, SIZE_H or SIZE_W (MEM_WRITE_PART only).
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  LINE_WIDTH  full line for WRITE_LINE; bits [31:0] for WRITE_PART.
- req_id  in  ID_WIDTH  tag echoed on the read response.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  LINE_WIDTH  read line.
- rsp_id  out  ID_WIDTH  tag of the read.
- err_misaligned  out  1  sticky flag: a misaligned partial write was dropped.

## Operation
- Address decode: offset = addr[log2(LINE_WIDTH/8)-1:0]; line index = next log2(DEPTH_LINES) bits. Upper bits are ignored, so addresses wrap modulo capacity.
- MEM_READ: line is sampled at acceptance and enters a LATENCY-stage delay line carrying {valid, id, data}, then a response FIFO of depth MAX_OUTSTANDING. Responses are returned strictly in acceptance order.
- MEM_WRITE_LINE: offset is ignored; the whole line is written at the acceptance edge. No response.
- MEM_WRITE_PART: writes 1, 2 or 4 bytes from req_wdata[7:0], [15:0] or [31:0] at offset; little-endian within the line. No response.
  - Misaligned partial write (half with addr[0]=1, word with addr[1:0]≠0): accepted, storage untouched, err_misaligned set until reset.
- Ordering: a read accepted after a write to the same line returns the written data. This holds because exactly one request is accepted per cycle and reads sample at acceptance.
- Credit counter outstanding:
  - +1 on read acceptance; −1 on rsp handshake.
  - Both in the same cycle: unchanged.
  - Width covers 0..MAX_OUTSTANDING.
- req_ready = (outstanding < MAX_OUTSTANDING). It is computed from registers only and is the same for all ops. Writes therefore also stall while reads are saturated.
- The delay line never stalls. The credit scheme guarantees FIFO space on arrival; FIFO overflow is an assertion failure.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_id=0, err_misaligned=0.
  - outstanding=0; delay-line valids and FIFO pointers cleared.
- Storage array is not reset; its contents survive reset.
- Read accepted at edge t: rsp_valid=1 from edge t+LATENCY, provided no older response is pending.
- rsp_valid stays high with rsp_data/rsp_id stable until a rsp_ready handshake. The next queued response appears the following cycle (no bubble when the FIFO holds more).
- Full credits: req_ready is low even if a pop occurs that cycle. It rises at the edge after the pop.
- Reset asserted mid-operation: all in-flight reads are discarded immediately and no stale response appears after deassertion.
- Writes take effect at the acceptance edge. A read accepted at edge t+1 observes them.

## Structure
- brisc_pkg adds:
  - typedef enum logic [1:0] mem_op_e {MEM_READ, MEM_WRITE_LINE, MEM_WRITE_PART};
  - typedef enum logic [1:0] mem_size_e {SIZE_B, SIZE_H, SIZE_W};
  - localparam MEM_WORD_BYTES = 4.
- Sub-module mem_rsp_fifo:
  - Parametrised width (LINE_WIDTH+ID_WIDTH) and depth.
  - Async active-high reset; push/pop/full/empty.
- Storage write-enable generation stays in the top module.

## Test plan
- Reset, WRITE_LINE addr 0x20 data 0x0F0E…00, then READ 0x20 id 1 → rsp_valid exactly LATENCY cycles after acceptance, data 0x0F0E…00, id 1.
- WRITE_PART SIZE_B addr 0x23 data 0xAA, WRITE_PART SIZE_H addr 0x26 data 0xBEEF, READ 0x20 → only bytes 3 and 6–7 changed, to 0xAA and 0xBEEF.
- WRITE_PART SIZE_W addr 0x22 → storage unchanged, err_misaligned=1 and remains 1 until reset.
- MAX_OUTSTANDING+1 back-to-back reads with rsp_ready=0 → req_ready low after the 4th acceptance. Then pulse rsp_ready once → req_ready returns high one cycle later and ids come out 0,1,2,3 in order.
- Reads in flight, reset pulsed for 1 cycle → rsp_valid=0, req_ready=1, no responses within 2×LATENCY after release.
- READ addr 0x220 with DEPTH_LINES=32, LINE_WIDTH=128 → returns the line at 0x020 (wrap-around).
